// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer: level-req consumer upstream, single-cycle ack producer downstream.
// Also reports occupancy, delivered-word count and a sticky overflow flag.
module handshake_fifo #(
    parameter int unsigned data_width = 32,
    parameter int unsigned depth      = 4,
    parameter int unsigned addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  in_req,
    input  logic                  in_ack,
    input  logic [data_width-1:0] in_data,
    input  logic                  out_req,
    output logic                  out_ack,
    output logic [data_width-1:0] out_data,
    output logic [addr_width:0]   level,
    output logic [31:0]           out_count,
    output logic                  overflow
);

    localparam int unsigned occ_width = addr_width + 1;
    localparam logic [occ_width-1:0] occ_full   = occ_width'(depth);
    localparam logic [occ_width-1:0] occ_thresh = occ_width'(depth - 2);
    localparam logic [occ_width-1:0] occ_one    = occ_width'(1);
    localparam logic [addr_width-1:0] ptr_one   = addr_width'(1);

    logic [data_width-1:0] mem [depth];
    logic [addr_width-1:0] wp;
    logic [addr_width-1:0] rp;
    logic [occ_width-1:0]  occ;

    logic                  push_c;
    logic                  pop_c;
    logic                  drop_c;
    logic [occ_width-1:0]  occ_next_c;

    // Push/pop decisions use the registered occupancy; a rejected ack at full never stores.
    always_comb begin
        push_c     = 1'b0;
        pop_c      = 1'b0;
        drop_c     = 1'b0;
        occ_next_c = occ;
        if (in_ack) begin
            if (occ == occ_full) begin
                drop_c = 1'b1;
            end else begin
                push_c = 1'b1;
            end
        end
        if (out_req && !out_ack && (occ != '0)) begin
            pop_c = 1'b1;
        end
        if (push_c && !pop_c) begin
            occ_next_c = occ + occ_one;
        end else if (pop_c && !push_c) begin
            occ_next_c = occ - occ_one;
        end
    end

    // Storage array carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wp] <= in_data;
        end
    end

    // Pointers, occupancy, handshake outputs and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp        <= '0;
            rp        <= '0;
            occ       <= '0;
            in_req    <= 1'b0;
            out_ack   <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else begin
            occ     <= occ_next_c;
            in_req  <= (occ_next_c <= occ_thresh);
            out_ack <= pop_c;
            if (push_c) begin
                wp <= wp + ptr_one;
            end
            if (pop_c) begin
                out_data  <= mem[rp];
                rp        <= rp + ptr_one;
                out_count <= out_count + 32'd1;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    assign level = occ;

endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized bench for handshake_fifo against a queue-based reference model.
module tb_handshake_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_req;
    logic          in_ack = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_req = 1'b0;
    logic          out_ack;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic [31:0]   out_count;
    logic          overflow;

    handshake_fifo #(.data_width(DW), .depth(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
        .level(level), .out_count(out_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stimulus controls
    bit          prod_en   = 1'b0;
    int unsigned prod_fail = 0;
    int unsigned prod_seq  = 0;
    int unsigned prod_limit = 0;
    bit          cons_en   = 1'b0;
    int unsigned cons_fail = 0;
    int unsigned seq_expect = 0;

    // Upstream producer: acks only when req is seen, never on two consecutive cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (prod_en) begin
                if (rst && in_req && !in_ack && prod_seq < prod_limit &&
                    $urandom_range(99) >= prod_fail) begin
                    in_ack  = 1'b1;
                    in_data = DW'(prod_seq);
                    prod_seq++;
                end else begin
                    in_ack = 1'b0;
                end
            end
        end
    end

    // Downstream consumer with random stalls.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cons_en) out_req = ($urandom_range(99) >= cons_fail);
        end
    end

    // Reference model: a queue of buffered words plus the observable flags.
    logic [DW-1:0] mq[$];
    bit            m_ack    = 1'b0;
    logic [DW-1:0] m_data   = '0;
    logic [31:0]   m_count  = '0;
    bit            m_ovf    = 1'b0;
    bit            m_in_req = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ack      = 1'b0;
            m_data     = '0;
            m_count    = '0;
            m_ovf      = 1'b0;
            m_in_req   = 1'b0;
            seq_expect = prod_seq;
        end else begin : model_step
            bit pu;
            bit po;
            po = out_req && !m_ack && (mq.size() > 0);
            pu = in_ack && (mq.size() < DEPTH);
            if (in_ack && !pu) m_ovf = 1'b1;
            if (po) begin
                m_data  = mq.pop_front();
                m_count = m_count + 32'd1;
            end
            if (pu) mq.push_back(in_data);
            m_ack    = po;
            m_in_req = (mq.size() <= DEPTH - 2);
        end
    end

    // Monitor: compare every output against the model each cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("in_req",    64'(in_req),    64'(m_in_req));
            check("out_ack",   64'(out_ack),   64'(m_ack));
            check("out_data",  64'(out_data),  64'(m_data));
            check("level",     64'(level),     64'(mq.size()));
            check("out_count", 64'(out_count), 64'(m_count));
            check("overflow",  64'(overflow),  64'(m_ovf));
            if (out_ack) begin
                check("seq", 64'(out_data), 64'(seq_expect));
                seq_expect++;
            end
        end
    end

    task automatic wait_seq(input int unsigned target, input int unsigned budget);
        for (int i = 0; i < budget; i++) begin
            if (seq_expect >= target) break;
            @(posedge clk);
            #2;
        end
        check("wait_seq_timeout", 64'(seq_expect >= target), 64'd1);
    endtask

    task automatic stop_producer();
        @(negedge clk);
        prod_en = 1'b0;
        @(posedge clk);
        #1;
        in_ack = 1'b0;
    endtask

    task automatic manual_consumer(input bit req);
        @(negedge clk);
        cons_en = 1'b0;
        @(posedge clk);
        #1;
        out_req = req;
    endtask

    // Drive one ack from the bench (producer disabled), then idle one cycle.
    task automatic force_ack(input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        in_ack  = 1'b1;
        in_data = d;
        @(posedge clk);
        #1;
        in_ack = 1'b0;
    endtask

    initial begin : main
        int unsigned base;
        #12;
        check("rst_in_req",    64'(in_req),    64'd0);
        check("rst_out_ack",   64'(out_ack),   64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_level",     64'(level),     64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_in_req", 64'(in_req), 64'd1);

        // 20 words, no stalls either side
        prod_limit = 20;
        prod_en    = 1'b1;
        cons_en    = 1'b1;
        wait_seq(20, 500);
        repeat (4) @(posedge clk);
        #2;
        check("count20",  64'(out_count), 64'd20);
        check("ovf_20",   64'(overflow),  64'd0);

        // Downstream stalled: upstream fills to the flow-control threshold
        manual_consumer(1'b0);
        prod_limit = 32'hFFFF_FFFF;
        repeat (30) @(posedge clk);
        #2;
        check("fill_level",  64'(level),    64'(DEPTH - 1));
        check("fill_in_req", 64'(in_req),   64'd0);
        check("fill_ovf",    64'(overflow), 64'd0);

        // Release downstream: stream resumes in order
        cons_fail = 0;
        cons_en   = 1'b1;
        wait_seq(60, 1000);

        // Both sides random at 30% stall
        prod_fail = 30;
        cons_fail = 30;
        wait_seq(2000, 40000);
        stop_producer();
        cons_fail = 0;
        wait_seq(prod_seq, 200);
        check("drain_level", 64'(level),    64'd0);
        check("random_ovf",  64'(overflow), 64'd0);

        // Overflow: fill completely by hand, then ack once more at full
        manual_consumer(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            force_ack(DW'(prod_seq));
            prod_seq++;
        end
        check("full_level", 64'(level), 64'(DEPTH));
        force_ack(32'h0000_DEAD);
        check("ovf_set",    64'(overflow), 64'd1);
        check("ovf_level",  64'(level),    64'(DEPTH));
        cons_en = 1'b1;
        wait_seq(prod_seq, 200);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset in the middle of a delivery
        manual_consumer(1'b0);
        for (int i = 0; i < 3; i++) begin
            force_ack(DW'(prod_seq));
            prod_seq++;
        end
        out_req = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_ack",   64'(out_ack), 64'd1);
        check("pre_rst_level", 64'(level),   64'd2);
        rst     = 1'b0;
        out_req = 1'b0;
        #1;
        check("mid_rst_in_req",    64'(in_req),    64'd0);
        check("mid_rst_out_ack",   64'(out_ack),   64'd0);
        check("mid_rst_out_data",  64'(out_data),  64'd0);
        check("mid_rst_level",     64'(level),     64'd0);
        check("mid_rst_out_count", 64'(out_count), 64'd0);
        check("mid_rst_overflow",  64'(overflow),  64'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_req", 64'(in_req), 64'd1);
        base      = prod_seq;
        prod_fail = 0;
        prod_en   = 1'b1;
        cons_en   = 1'b1;
        wait_seq(base + 6, 300);
        check("post_rst_count", 64'(out_count >= 32'd6), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/handshake_fifo.md
# handshake_fifo

Elastic buffer on the req/ack stream between an `arf` output port (`dout_req_N`/`dout_ack_N`/`dout_N`) and a downstream consumer. Toward the upstream side it behaves like a consumer and holds a level `req`; toward the downstream side it behaves like a producer and answers with single-cycle `ack` pulses plus registered data. It absorbs consumer stalls (consumer `fail_rate` > 0) without back-pressuring the dataflow graph until `depth` words are buffered. It also reports occupancy, a transfer count and a sticky overflow flag for throughput benches.

## Interface
- `data_width`, 32: width of the data word.
- `depth`, 4: number of storage entries. Must be a power of 2 and at least 2.
- `addr_width`, `$clog2(depth)`: pointer width. Derived; do not override.
- `clk`  in  1: clock. All state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low. While `rst` = 0 all state is held at its reset value.
- `in_req`  out  1: request to the upstream producer (level, registered).
- `in_ack`  in  1: upstream ack pulse. `in_data` is valid in the same cycle.
- `in_data`  in  `data_width`: upstream data.
- `out_req`  in  1: downstream request (level).
- `out_ack`  out  1: ack pulse to downstream (registered).
- `out_data`  out  `data_width`: registered data, valid while `out_ack` = 1 and held afterwards.
- `level`  out  `addr_width+1`: current occupancy, 0..`depth`.
- `out_count`  out  32: number of words delivered downstream since reset.
- `overflow`  out  1: sticky flag, set when an `in_ack` arrives while the buffer is full.

## Operation
- Storage is a circular array with write pointer `wp`, read pointer `rp` (both `addr_width` bits, wrapping mod `depth`) and occupancy counter `occ` (`addr_width+1` bits). `level` = `occ`.
- Push: on an edge where `in_ack` = 1 and `occ` < `depth`:
  - store `in_data` at `wp`;
  - `wp` ← `wp`+1.
- Overflow: on an edge where `in_ack` = 1 and `occ` = `depth`:
  - discard the word and leave `wp` unchanged;
  - set `overflow` ← 1. It clears only on reset.
- Pop: on an edge where `out_req` = 1, `out_ack` = 0 and `occ` > 0:
  - `out_data` ← mem[`rp`];
  - `rp` ← `rp`+1;
  - `out_ack` ← 1;
  - `out_count` ← `out_count`+1 (wraps mod 2^32).
- On every other edge `out_ack` ← 0 and `out_data` holds its value.
- `occ` update:
  - push only: +1;
  - pop only: −1;
  - push and pop on the same edge: unchanged;
  - neither: unchanged.
- A pop reads the registered `occ` and the current mem[`rp`]. A word pushed on edge t can be popped no earlier than edge t+1. There is no bypass path.
- `in_req` flow control: `in_req` ← 1 iff `occ_next` ≤ `depth`−2, where `occ_next` is the occupancy after the current edge's push/pop.
  - This leaves one free slot for the single ack that can already be in flight when `in_req` falls.
  - Upstream never acks on two consecutive cycles, so at most one ack is in flight.
  - With a compliant upstream, `overflow` must stay 0.
- No internal FSM beyond the pointers and counters. The output side is a two-state pulse: IDLE (`out_ack`=0) → ACK (`out_ack`=1) on a pop, then ACK → IDLE on the next edge unconditionally.

## Timing
- Reset values:
  - `in_req`=0, `out_ack`=0, `out_data`=0;
  - `level`=0, `out_count`=0, `overflow`=0;
  - `wp`=`rp`=0, memory contents don't-care.
- First edge after `rst` rises: `in_req` ← 1 (since `occ` = 0 ≤ `depth`−2).
- Latency: `in_ack` sampled at edge t; `out_ack` pulse can be visible after edge t+1 (2 edges from the `in_ack` sample to the `out_ack` rise, assuming `out_req` is high).
- Peak downstream rate: one word every 2 cycles, because `out_ack` cannot repeat on consecutive edges. This matches the producer protocol.
- Full (`occ`=`depth`): `in_req` is already 0. A simultaneous push and pop at `occ`=`depth` is impossible because the push is rejected first. Define an ack at full as overflow even when a pop happens on the same edge.
- Empty: an `out_req` with `occ`=0 produces no ack. A push on the same edge does not ack on that edge.
- Pointer wrap: `wp` and `rp` roll over from `depth`−1 to 0 with no bubble.
- Reset asserted mid-transfer: all outputs return to their reset values immediately (asynchronously). Buffered words are lost. An `in_ack` arriving during reset is ignored.

## Test plan
- Reset, then an upstream producer at `fail_rate` 0 and a consumer at `fail_rate` 0 for 20 words → consumer receives 0,1,…,19 in order; `overflow`=0; `out_count`=20.
- `depth`=4, `out_req` held 0, upstream always ready → `in_req` falls when `level` reaches 3; `level` settles at 3 or 4 and never exceeds 4; `overflow`=0.
- Continue the previous case by raising `out_req` → 4 words drain in order, one `out_ack` every 2 cycles; `in_req` returns to 1 once `level` ≤ 2; the stream resumes with no gap in the value sequence.
- Force `in_ack`=1 with `in_data`=0xDEAD while `level`=4 → `overflow`=1 on the next edge; `level` stays 4; 0xDEAD never appears at `out_data`.
- Run producer and consumer both at `fail_rate` 30 for 5000 words with `depth`=8 → every value 0..4999 is delivered exactly once in order; pointers wrap more than 600 times; `out_count`=5000.
- Pull `rst` low for one half-cycle while `level`=2 and `out_ack`=1 → all outputs read 0 during reset; after release `in_req`=1 after the first edge and the next delivered word is the first one pushed after reset.
